rx_fifo: RTL

Synchronous receive FIFO sitting directly downstream of receiver_native. It accepts words from the receiver's write port (dout/we/full) and buffers them for the host-side consumer through a first-word-fall-through read port. It also provides an occupancy count and a sticky overrun flag for words the receiver delivered while the buffer was full.

---
 rtl/rx_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous receive FIFO with a first-word-fall-through read port.
//
// Sits directly behind the serial receiver. Words arrive on din/we and are
// held until the host-side consumer pops them with re. The oldest word is
// always presented on dout while empty=0.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst           asynchronous active-low reset
//   din, we       write port (receiver's dout / we)
//   full          all DEPTH entries in use (receiver's full)
//   dout, re      FWFT read data and pop strobe
//   empty         no entries stored
//   count         number of stored entries, 0..DEPTH
//   overrun       sticky: a write arrived while full and was dropped
//   clear_overrun synchronous clear of overrun (a new overrun wins)
module rx_fifo #(
  parameter int unsigned WORD_WIDTH = 32'd8,
  parameter int unsigned DEPTH_LOG2 = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  we,
  output logic                  full,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clear_overrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = (DEPTH_LOG2 + 1)'(1);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra bit so that full and empty are distinguishable.
  logic [DEPTH_LOG2:0] wptr_reg;
  logic [DEPTH_LOG2:0] rptr_reg;
  logic                overrun_reg;

  logic do_write;
  logic do_pop;

  always_comb begin
    count = wptr_reg - rptr_reg;
    empty = (count == '0);
    full  = (count == DEPTH_CNT);
  end

  // full is never bypassed by a simultaneous pop: a write while full drops.
  assign do_write = we & ~full;
  assign do_pop   = re & ~empty;

  // Combinational read of the head entry gives the fall-through behaviour.
  assign dout    = empty ? '0 : mem[rptr_reg[DEPTH_LOG2-1:0]];
  assign overrun = overrun_reg;

  // Storage has no reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr_reg[DEPTH_LOG2-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_write) begin
        wptr_reg <= wptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rptr_reg <= rptr_reg + PTR_ONE;
      end
      // A fresh overrun takes priority over a clear in the same cycle.
      if (we && full) begin
        overrun_reg <= 1'b1;
      end else if (clear_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

endmodule
